instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 178 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory with a streaming loader and a 1-cycle fetch port.
//
// Two states: LOAD streams an image into the memory starting at word 0,
// RUN serves instruction fetches. The memory array itself is never reset,
// so an image (or part of one) survives a reset or a reload that writes
// fewer words.
//
// Handshakes:
//   load  : a word transfers on every cycle where load_valid && load_ready.
//           load_ready is a pure function of state (high in LOAD) and does
//           not depend on load_valid. load_last marks the final word.
//   fetch : a request is accepted on every cycle where fetch_req &&
//           fetch_ready; fetch_ready never depends on fetch_req. The
//           response appears one cycle after acceptance with fetch_valid=1
//           and is held for as long as fetch_stall=1.
module instr_mem_loader #(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    // loader side
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_ovf,
    // fetch side
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_stall,
    input  logic        fetch_flush,
    output logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic        fetch_fault,
    // debug: current FSM state, 0 = LOAD, 1 = RUN
    output logic        dbg_state
);

    localparam int AW = $clog2(DEPTH);

    // The pointer needs one extra bit so that "full" (ptr == DEPTH) is
    // representable and distinguishable from word 0.
    localparam logic [AW:0] PTR_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] ptr_q, ptr_d;
    logic        ovf_q, ovf_d;
    logic        fv_q, fv_d;
    logic [31:0] fi_q, fi_d;
    logic        ff_q, ff_d;

    logic [31:0] mem [DEPTH];
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic        addr_misaligned;
    logic        addr_out_of_range;
    logic        rd_fault;
    logic        fetch_accept;

    // The read index uses only the low AW word-address bits, so the array
    // can never be indexed out of range; the range check below decides
    // whether the word read is actually returned.
    assign addr_misaligned   = (fetch_addr[1:0] != 2'b00);
    assign addr_out_of_range = (fetch_addr[31:2] >= 30'(DEPTH));
    assign rd_fault          = addr_misaligned || addr_out_of_range;
    assign mem_rdata         = mem[fetch_addr[AW+1:2]];

    assign fetch_ready  = (state_q == ST_RUN) && !fetch_stall;
    assign fetch_accept = fetch_req && fetch_ready;

    assign load_ready  = (state_q == ST_LOAD);
    assign load_ovf    = ovf_q;
    assign fetch_valid = fv_q;
    assign fetch_instr = fi_q;
    assign fetch_fault = ff_q;
    assign dbg_state   = state_q;

    // Next-state and datapath control for both the loader and fetch port.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        fv_d    = fv_q;
        fi_d    = fi_q;
        ff_d    = ff_q;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (load_start) begin
                    // Restart the image from word 0.
                    ptr_d = '0;
                    ovf_d = 1'b0;
                end else if (load_valid) begin
                    if (ptr_q == PTR_FULL) begin
                        // Image larger than the memory: drop the word.
                        ovf_d = 1'b1;
                    end else begin
                        // Gating with rst_n keeps a word that is on the bus
                        // while reset is held from landing in mem[0].
                        mem_we = rst_n;
                        ptr_d  = ptr_q + PTR_ONE;
                    end
                    if (load_last) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (load_start) begin
                    // Reload: drop any response in flight and stop fetching.
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                    fv_d    = 1'b0;
                end else if (fetch_accept) begin
                    // A fresh acceptance wins over a same-cycle flush.
                    fv_d = 1'b1;
                    ff_d = rd_fault;
                    fi_d = rd_fault ? NOP_WORD : mem_rdata;
                end else if (fetch_flush || !fetch_stall) begin
                    // Flush drops the response even under stall; otherwise
                    // the response is consumed. The word itself is kept.
                    fv_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Loader pointer, overflow flag and registered fetch response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            ovf_q <= 1'b0;
            fv_q  <= 1'b0;
            fi_q  <= NOP_WORD;
            ff_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            fv_q  <= fv_d;
            fi_q  <= fi_d;
            ff_q  <= ff_d;
        end
    end

    // Instruction storage; intentionally not reset so contents persist.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[AW-1:0]] <= load_data;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed scenarios followed by
// a randomized fetch phase, all checked against a word-level reference
// model (an array image plus the current response registers).
module tb_instr_mem_loader;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        load_ovf;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_stall = 1'b0;
    logic        fetch_flush = 1'b0;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic        dbg_state;

    // clock / reset block
    always #5 clk = ~clk;

    instr_mem_loader #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_ovf    (load_ovf),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .fetch_flush (fetch_flush),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
        .dbg_state   (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    // reference model
    logic [31:0] ref_mem [DEPTH];
    int          m_ptr;
    logic        m_ovf;
    logic        m_run;
    logic        m_v;
    logic [31:0] m_instr;
    logic        m_fault;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] model_fetch(input logic [31:0] a);
        int idx;
        if (a[1:0] != 2'b00 || (a >> 2) >= 32'(DEPTH)) return {1'b1, NOP};
        idx = int'(a >> 2);
        return {1'b0, ref_mem[idx]};
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_ovf   = 1'b0;
        m_run   = 1'b0;
        m_v     = 1'b0;
        m_instr = NOP;
        m_fault = 1'b0;
    endtask

    task automatic check_ctrl(input string tag);
        chk({tag, ".load_ready"}, 32'(load_ready), 32'(!m_run));
        chk({tag, ".fetch_ready"}, 32'(fetch_ready), 32'(m_run));
        chk({tag, ".load_ovf"}, 32'(load_ovf), 32'(m_ovf));
        chk({tag, ".dbg_state"}, 32'(dbg_state), 32'(m_run));
    endtask

    task automatic check_fetch(input string tag);
        chk({tag, ".valid"}, 32'(fetch_valid), 32'(m_v));
        chk({tag, ".instr"}, fetch_instr, m_instr);
        chk({tag, ".fault"}, 32'(fetch_fault), 32'(m_fault));
    endtask

    // driver: one load word (called in LOAD state only)
    task automatic load_word(input logic [31:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (m_ptr < DEPTH) begin
            ref_mem[m_ptr] = data;
            m_ptr++;
        end else begin
            m_ovf = 1'b1;
        end
        if (last) m_run = 1'b1;
        chk("load.ovf", 32'(load_ovf), 32'(m_ovf));
    endtask

    // driver: load_start pulse
    task automatic start_load();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        m_ptr = 0;
        m_ovf = 1'b0;
        if (m_run) m_v = 1'b0;
        m_run = 1'b0;
        check_ctrl("start");
        chk("start.valid", 32'(fetch_valid), 32'(m_v));
    endtask

    // driver: one fetch-port cycle, checked against the model afterwards
    task automatic fetch_cycle(input logic req, input logic [31:0] addr,
                               input logic stall, input logic flush);
        logic        acc;
        logic [32:0] r;
        fetch_req   = req;
        fetch_addr  = addr;
        fetch_stall = stall;
        fetch_flush = flush;
        acc = req && m_run && !stall;
        r   = model_fetch(addr);
        @(posedge clk); #1;
        fetch_req   = 1'b0;
        fetch_stall = 1'b0;
        fetch_flush = 1'b0;
        if (acc) begin
            m_v     = 1'b1;
            m_fault = r[32];
            m_instr = r[31:0];
        end else if (flush || !stall) begin
            m_v = 1'b0;
        end
        check_fetch("fetch");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, c_word;
        model_reset();

        // ---- reset values, asynchronous
        #2 rst_n = 1'b0;
        #1;
        check_ctrl("reset");
        check_fetch("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_ctrl("post_reset");

        // ---- basic load of 4 words, then back-to-back fetch
        exp_q = {32'h00100093, 32'h00200113, 32'h0020c463, 32'h00300193};
        load_word(32'h00100093, 1'b0);
        load_word(32'h00200113, 1'b0);
        load_word(32'h0020c463, 1'b0);
        load_word(32'h00300193, 1'b1);
        check_ctrl("basic_run");
        for (int i = 0; i < 4; i++) begin
            fetch_cycle(1'b1, 32'(i * 4), 1'b0, 1'b0);
            chk("basic.word", fetch_instr, exp_q.pop_front());
            chk("basic.valid", 32'(fetch_valid), 32'd1);
        end
        fetch_cycle(1'b0, 32'h0, 1'b0, 1'b0);   // valid drops, word holds
        chk("idle.instr_hold", fetch_instr, 32'h00300193);

        // ---- fault fetches
        fetch_cycle(1'b1, 32'h6, 1'b0, 1'b0);
        chk("fault_misaligned", {fetch_fault, fetch_valid, fetch_instr[29:0]}, {2'b11, NOP[29:0]});
        fetch_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        fetch_cycle(1'b1, 32'(4 * DEPTH), 1'b0, 1'b0);
        chk("fault_range", {fetch_fault, fetch_valid, fetch_instr[29:0]}, {2'b11, NOP[29:0]});

        // ---- stall holds output, flush under stall clears valid
        fetch_cycle(1'b1, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            fetch_cycle(1'b1, 32'h4, 1'b1, 1'b0);
            chk("stall.hold", fetch_instr, 32'h00100093);
        end
        fetch_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("flush.valid", 32'(fetch_valid), 32'd0);

        // ---- flush with same-cycle acceptance: new response wins
        fetch_cycle(1'b1, 32'h8, 1'b0, 1'b1);
        chk("flush_accept.valid", 32'(fetch_valid), 32'd1);

        // ---- overflow: DEPTH+1 words
        start_load();
        for (int i = 0; i <= DEPTH; i++) load_word($urandom(), i == DEPTH);
        chk("ovf.flag", 32'(load_ovf), 32'd1);
        check_ctrl("ovf_run");
        for (int i = 0; i < DEPTH; i++) fetch_cycle(1'b1, 32'(i * 4), 1'b0, 1'b0);
        check_ctrl("ovf_sticky");

        // ---- reload 2 words from RUN; word 2 keeps the previous image
        fetch_cycle(1'b1, 32'h0, 1'b0, 1'b0);
        start_load();
        load_word(32'hCAFE_0001, 1'b0);
        load_word(32'hCAFE_0002, 1'b1);
        fetch_cycle(1'b1, 32'h0, 1'b0, 1'b0);
        chk("reload.w0", fetch_instr, 32'hCAFE_0001);
        fetch_cycle(1'b1, 32'h4, 1'b0, 1'b0);
        chk("reload.w1", fetch_instr, 32'hCAFE_0002);
        fetch_cycle(1'b1, 32'h8, 1'b0, 1'b0);

        // ---- randomized fetch traffic
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                7: a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                8: a = 32'(4 * DEPTH) + (32'($urandom_range(0, 255)) << 2);
                default: a = $urandom();
            endcase
            fetch_cycle($urandom_range(0, 3) != 0, a,
                        $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        // ---- reset during the 3rd load word
        start_load();
        load_word(32'hBEEF_0000, 1'b0);
        load_word(32'hBEEF_0001, 1'b0);
        c_word     = 32'hBEEF_0002;
        load_valid = 1'b1;
        load_data  = c_word;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_ctrl("midload_reset");
        check_fetch("midload_reset");
        load_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_ctrl("midload_release");
        load_word(32'hD00D_0000, 1'b1);
        fetch_cycle(1'b1, 32'h0, 1'b0, 1'b0);
        chk("persist.w0", fetch_instr, 32'hD00D_0000);
        fetch_cycle(1'b1, 32'h4, 1'b0, 1'b0);
        chk("persist.w1", fetch_instr, 32'hBEEF_0001);
        fetch_cycle(1'b1, 32'h8, 1'b0, 1'b0);   // model: 3rd word never landed
        fetch_cycle(1'b0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
